// File: rtl/usb_tx_sequencer.sv
// usb_tx_sequencer
//   Transmit-side packet sequencer in front of the piso serializer. Takes one
//   packet command at a time and requests its fields from piso in order:
//     IN token : SYNC, PID_READ, READ_ADDRESS
//     ACK/NAK  : SYNC, PID_ACK / PID_NAK
//     DATA     : SYNC, PASS_THROUGH (cmd_len bytes, skipped when cmd_len = 0)
//   Field completion is measured by counting piso_data_last pulses; a
//   watchdog aborts the packet when piso stops producing bytes.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_type, cmd_len         0=IN 1=ACK 2=NAK 3=DATA; DATA payload length
//   piso_data_last            pulse on last bit of each serialized byte
//   request_serial_data(_type) field request to piso
//   tx_busy, tx_done, tx_error packet status (done/error are 1-cycle pulses)
//   dbg_state                 current FSM state
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high in IDLE and in the DONE cycle,
// so a waiting command follows a finished packet with no idle gap.
// All outputs come straight from flops loaded with next-state values.
module usb_tx_sequencer #(
  parameter int LEN_WIDTH      = 7,
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_type,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 piso_data_last,
  output logic                 request_serial_data,
  output logic [2:0]           request_serial_data_type,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_error,
  output logic [2:0]           dbg_state
);

  // request_serial_data_type encodings; 0 means no field selected
  localparam logic [2:0] REQUEST_SERIAL_DATA_TYPE_SYNC         = 3'd1;
  localparam logic [2:0] REQUEST_SERIAL_DATA_TYPE_PID_READ     = 3'd2;
  localparam logic [2:0] REQUEST_SERIAL_DATA_TYPE_READ_ADDRESS = 3'd3;
  localparam logic [2:0] REQUEST_SERIAL_DATA_TYPE_PID_ACK      = 3'd4;
  localparam logic [2:0] REQUEST_SERIAL_DATA_TYPE_PID_NAK      = 3'd5;
  localparam logic [2:0] REQUEST_SERIAL_DATA_TYPE_PASS_THROUGH = 3'd6;

  localparam int HOLD_W = $clog2(2*HOLD_CYCLES+1);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES+1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} state_e;

  state_e               state_q, state_d;
  logic [1:0]           ctype_q, ctype_d;
  logic [1:0]           field_q, field_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] byte_q, byte_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [WD_W-1:0]      wd_q, wd_d;

  logic       ready_q, req_q, busy_q, done_q, err_q;
  logic [2:0] type_q;

  function automatic logic [2:0] field_type(input logic [1:0] ct, input logic [1:0] idx);
    logic [2:0] t;
    t = REQUEST_SERIAL_DATA_TYPE_SYNC;
    if (idx != 2'd0) begin
      case (ct)
        2'd0:    t = (idx == 2'd1) ? REQUEST_SERIAL_DATA_TYPE_PID_READ
                                   : REQUEST_SERIAL_DATA_TYPE_READ_ADDRESS;
        2'd1:    t = REQUEST_SERIAL_DATA_TYPE_PID_ACK;
        2'd2:    t = REQUEST_SERIAL_DATA_TYPE_PID_NAK;
        default: t = REQUEST_SERIAL_DATA_TYPE_PASS_THROUGH;
      endcase
    end
    return t;
  endfunction

  logic [2:0]           cur_type;
  logic [LEN_WIDTH-1:0] cur_bytes;
  logic [HOLD_W-1:0]    cur_hold;
  logic [1:0]           last_idx;
  logic                 byte_inc;
  logic [LEN_WIDTH-1:0] byte_next;
  logic                 bytes_done;
  logic                 timeout;
  logic [WD_W-1:0]      wd_next;

  always_comb begin
    cur_type = field_type(ctype_q, field_q);
    case (cur_type)
      REQUEST_SERIAL_DATA_TYPE_READ_ADDRESS: cur_bytes = LEN_WIDTH'(2);
      REQUEST_SERIAL_DATA_TYPE_PASS_THROUGH: cur_bytes = len_q;
      default:                               cur_bytes = LEN_WIDTH'(1);
    endcase
    cur_hold = (cur_type == REQUEST_SERIAL_DATA_TYPE_READ_ADDRESS) ?
               HOLD_W'(2*HOLD_CYCLES) : HOLD_W'(HOLD_CYCLES);
    case (ctype_q)
      2'd0:    last_idx = 2'd2;
      2'd3:    last_idx = (len_q == '0) ? 2'd0 : 2'd1;  // empty DATA: SYNC only
      default: last_idx = 2'd1;
    endcase
    // Counter saturates at the field size so stray pulses are ignored
    byte_inc   = piso_data_last && (byte_q != cur_bytes);
    byte_next  = byte_q + {{(LEN_WIDTH-1){1'b0}}, byte_inc};
    bytes_done = (byte_next == cur_bytes);
    // A byte arriving on the timeout cycle wins: it restarts the watchdog
    timeout    = !piso_data_last && (wd_q == WD_W'(TIMEOUT_CYCLES-1));
    wd_next    = piso_data_last ? '0 : wd_q + WD_W'(1);
  end

  always_comb begin
    state_d = state_q;
    ctype_d = ctype_q;
    field_d = field_q;
    len_d   = len_q;
    byte_d  = byte_q;
    hold_d  = hold_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (cmd_valid) begin
          ctype_d = cmd_type;
          len_d   = cmd_len;
          field_d = 2'd0;
          byte_d  = '0;
          hold_d  = '0;
          wd_d    = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        byte_d = byte_next;
        wd_d   = wd_next;
        if (timeout) begin
          state_d = S_ERR;
        end else if (cur_type == REQUEST_SERIAL_DATA_TYPE_PASS_THROUGH) begin
          if (bytes_done) state_d = S_WAIT;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
          if (hold_q == cur_hold - HOLD_W'(1)) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        byte_d = byte_next;
        wd_d   = wd_next;
        if (bytes_done) begin
          if (field_q == last_idx) begin
            state_d = S_DONE;
          end else begin
            field_d = field_q + 2'd1;
            byte_d  = '0;
            hold_d  = '0;
            wd_d    = '0;
            state_d = S_REQ;
          end
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;  // S_ERR: abandon packet, no retry
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ctype_q <= '0;
      field_q <= '0;
      len_q   <= '0;
      byte_q  <= '0;
      hold_q  <= '0;
      wd_q    <= '0;
      ready_q <= 1'b1;
      req_q   <= 1'b0;
      type_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctype_q <= ctype_d;
      field_q <= field_d;
      len_q   <= len_d;
      byte_q  <= byte_d;
      hold_q  <= hold_d;
      wd_q    <= wd_d;
      ready_q <= (state_d == S_IDLE) || (state_d == S_DONE);
      req_q   <= (state_d == S_REQ);
      busy_q  <= (state_d == S_REQ) || (state_d == S_WAIT);
      type_q  <= ((state_d == S_REQ) || (state_d == S_WAIT)) ?
                 field_type(ctype_d, field_d) : 3'd0;
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_ERR);
    end
  end

  assign cmd_ready                = ready_q;
  assign request_serial_data      = req_q;
  assign request_serial_data_type = type_q;
  assign tx_busy                  = busy_q;
  assign tx_done                  = done_q;
  assign tx_error                 = err_q;
  assign dbg_state                = state_q;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Bench for usb_tx_sequencer: per-cycle expectation rows (phase + field type)
// are queued per scenario and replayed; reset behaviour is hand-sequenced.
module tb_usb_tx_sequencer;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_SYNC = 3'd1;
  localparam logic [2:0] T_READ = 3'd2;
  localparam logic [2:0] T_ADDR = 3'd3;
  localparam logic [2:0] T_ACK  = 3'd4;
  localparam logic [2:0] T_NAK  = 3'd5;
  localparam logic [2:0] T_PASS = 3'd6;

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_WAIT = 2;
  localparam int P_DONE = 3;
  localparam int P_ERR  = 4;

  logic       clk, rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_type;
  logic [6:0] cmd_len;
  logic       piso_data_last;
  logic       request_serial_data;
  logic [2:0] request_serial_data_type;
  logic       tx_busy, tx_done, tx_error;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  usb_tx_sequencer #(.LEN_WIDTH(7), .HOLD_CYCLES(8), .TIMEOUT_CYCLES(64)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .cmd_valid                (cmd_valid),
    .cmd_ready                (cmd_ready),
    .cmd_type                 (cmd_type),
    .cmd_len                  (cmd_len),
    .piso_data_last           (piso_data_last),
    .request_serial_data      (request_serial_data),
    .request_serial_data_type (request_serial_data_type),
    .tx_busy                  (tx_busy),
    .tx_done                  (tx_done),
    .tx_error                 (tx_error),
    .dbg_state                (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       v;
    logic [1:0] ct;
    logic [6:0] len;
    logic       last;
    logic       rdy, req, busy, done, err;
    logic [2:0] ty;
  } row_t;

  row_t rows[$];

  // Expected outputs derived from the phase the packet should be in
  task automatic add(input int n, input logic v, input logic [1:0] ct,
                     input logic [6:0] len, input logic last,
                     input int ph, input logic [2:0] ty);
    row_t r;
    r.n = n; r.v = v; r.ct = ct; r.len = len; r.last = last;
    r.rdy  = (ph == P_IDLE) || (ph == P_DONE);
    r.req  = (ph == P_REQ);
    r.busy = (ph == P_REQ) || (ph == P_WAIT);
    r.done = (ph == P_DONE);
    r.err  = (ph == P_ERR);
    r.ty   = ty;
    rows.push_back(r);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  function automatic logic [7:0] outs(input logic mask_ty);
    return {cmd_ready, request_serial_data, tx_busy, tx_done, tx_error,
            mask_ty ? request_serial_data_type : 3'd0};
  endfunction

  // Each cycle: check outputs at the falling edge, then drive that cycle's inputs
  task automatic run_rows(input string tag);
    foreach (rows[i]) begin
      for (int k = 0; k < rows[i].n; k++) begin
        @(negedge clk);
        chk($sformatf("%s_row%0d_cyc%0d", tag, i, k), outs(rows[i].req),
            {rows[i].rdy, rows[i].req, rows[i].busy, rows[i].done, rows[i].err,
             rows[i].req ? rows[i].ty : 3'd0});
        cmd_valid      = rows[i].v;
        cmd_type       = rows[i].ct;
        cmd_len        = rows[i].len;
        piso_data_last = rows[i].last;
      end
    end
    rows.delete();
  endtask

  task automatic add_ack_packet();
    add(1, 1, 2'd1, 7'd0, 0, P_IDLE, T_NONE);  // accept
    add(8, 0, 2'd0, 7'd0, 0, P_REQ,  T_SYNC);
    add(3, 0, 2'd0, 7'd0, 0, P_WAIT, T_NONE);
    add(1, 0, 2'd0, 7'd0, 1, P_WAIT, T_NONE);
    add(8, 0, 2'd0, 7'd0, 0, P_REQ,  T_ACK);
    add(1, 0, 2'd0, 7'd0, 1, P_WAIT, T_NONE);
    add(1, 0, 2'd0, 7'd0, 0, P_DONE, T_NONE);
    add(2, 0, 2'd0, 7'd0, 0, P_IDLE, T_NONE);
  endtask

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_type = 2'd0; cmd_len = 7'd0; piso_data_last = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_values", outs(1'b1), 8'b1_0_0_0_0_000);
    rst = 1'b1;

    // ACK packet from idle
    add(2, 0, 2'd0, 7'd0, 0, P_IDLE, T_NONE);
    add_ack_packet();
    // IN token: SYNC(8) PID_READ(8) READ_ADDRESS(16), four pulses total
    add(1, 1, 2'd0, 7'd0, 0, P_IDLE, T_NONE);
    add(2, 0, 2'd0, 7'd0, 0, P_REQ,  T_SYNC);
    add(1, 0, 2'd0, 7'd0, 1, P_REQ,  T_SYNC);  // byte done during hold
    add(5, 0, 2'd0, 7'd0, 0, P_REQ,  T_SYNC);
    add(1, 0, 2'd0, 7'd0, 0, P_WAIT, T_NONE);  // single WAIT cycle
    add(8, 0, 2'd0, 7'd0, 0, P_REQ,  T_READ);
    add(1, 0, 2'd0, 7'd0, 0, P_WAIT, T_NONE);
    add(1, 0, 2'd0, 7'd0, 1, P_WAIT, T_NONE);
    add(5, 0, 2'd0, 7'd0, 0, P_REQ,  T_ADDR);
    add(1, 0, 2'd0, 7'd0, 1, P_REQ,  T_ADDR);
    add(10, 0, 2'd0, 7'd0, 0, P_REQ, T_ADDR);
    add(2, 0, 2'd0, 7'd0, 0, P_WAIT, T_NONE);  // one of two bytes so far
    add(1, 0, 2'd0, 7'd0, 1, P_WAIT, T_NONE);
    add(1, 0, 2'd0, 7'd0, 0, P_DONE, T_NONE);
    add(1, 0, 2'd0, 7'd0, 0, P_IDLE, T_NONE);
    // DATA len 3, extra pulse after the last byte is ignored
    add(1, 1, 2'd3, 7'd3, 0, P_IDLE, T_NONE);
    add(8, 0, 2'd0, 7'd0, 0, P_REQ,  T_SYNC);
    add(1, 0, 2'd0, 7'd0, 1, P_WAIT, T_NONE);
    add(1, 0, 2'd0, 7'd0, 0, P_REQ,  T_PASS);
    add(1, 0, 2'd0, 7'd0, 1, P_REQ,  T_PASS);
    add(2, 0, 2'd0, 7'd0, 0, P_REQ,  T_PASS);
    add(1, 0, 2'd0, 7'd0, 1, P_REQ,  T_PASS);
    add(1, 0, 2'd0, 7'd0, 0, P_REQ,  T_PASS);
    add(1, 0, 2'd0, 7'd0, 1, P_REQ,  T_PASS);  // third byte
    add(1, 0, 2'd0, 7'd0, 1, P_WAIT, T_NONE);  // extra pulse, saturated
    add(1, 0, 2'd0, 7'd0, 0, P_DONE, T_NONE);
    add(1, 0, 2'd0, 7'd0, 0, P_IDLE, T_NONE);
    // DATA len 0 completes after SYNC; ACK presented during DONE
    add(1, 1, 2'd3, 7'd0, 0, P_IDLE, T_NONE);
    add(8, 0, 2'd0, 7'd0, 0, P_REQ,  T_SYNC);
    add(1, 0, 2'd0, 7'd0, 1, P_WAIT, T_NONE);
    add(1, 1, 2'd1, 7'd0, 0, P_DONE, T_NONE);  // back-to-back accept
    add(8, 0, 2'd0, 7'd0, 0, P_REQ,  T_SYNC);
    add(1, 0, 2'd0, 7'd0, 1, P_WAIT, T_NONE);
    add(8, 0, 2'd0, 7'd0, 0, P_REQ,  T_ACK);
    add(1, 0, 2'd0, 7'd0, 1, P_WAIT, T_NONE);
    add(1, 0, 2'd0, 7'd0, 0, P_DONE, T_NONE);
    add(1, 0, 2'd0, 7'd0, 0, P_IDLE, T_NONE);
    // NAK with no bytes: 64th cycle of SYNC detects timeout, ERR next
    add(1, 1, 2'd2, 7'd0, 0, P_IDLE, T_NONE);
    add(8, 0, 2'd0, 7'd0, 0, P_REQ,  T_SYNC);
    add(56, 0, 2'd0, 7'd0, 0, P_WAIT, T_NONE);
    add(1, 0, 2'd0, 7'd0, 0, P_ERR,  T_NONE);
    add(2, 0, 2'd0, 7'd0, 0, P_IDLE, T_NONE);
    // NAK with the byte arriving exactly on the timeout cycle
    add(1, 1, 2'd2, 7'd0, 0, P_IDLE, T_NONE);
    add(8, 0, 2'd0, 7'd0, 0, P_REQ,  T_SYNC);
    add(55, 0, 2'd0, 7'd0, 0, P_WAIT, T_NONE);
    add(1, 0, 2'd0, 7'd0, 1, P_WAIT, T_NONE);
    add(8, 0, 2'd0, 7'd0, 0, P_REQ,  T_NAK);
    add(1, 0, 2'd0, 7'd0, 1, P_WAIT, T_NONE);
    add(1, 0, 2'd0, 7'd0, 0, P_DONE, T_NONE);
    add(1, 0, 2'd0, 7'd0, 0, P_IDLE, T_NONE);
    run_rows("table");

    // Reset asserted during the PID_READ hold of an IN token
    @(negedge clk); cmd_valid = 1'b1; cmd_type = 2'd0;
    @(negedge clk); cmd_valid = 1'b0;
    chk("in_sync_req", {4'd0, request_serial_data, request_serial_data_type}, {4'd0, 1'b1, T_SYNC});
    repeat (8) @(negedge clk);
    chk("in_wait", {7'd0, request_serial_data}, 8'd0);
    piso_data_last = 1'b1;
    @(negedge clk); piso_data_last = 1'b0;
    chk("in_pid_read", {4'd0, request_serial_data, request_serial_data_type}, {4'd0, 1'b1, T_READ});
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_async", outs(1'b1), 8'b1_0_0_0_0_000);
    chk("rst_state", {5'd0, dbg_state}, 8'd0);
    @(negedge clk);
    chk("rst_held", outs(1'b1), 8'b1_0_0_0_0_000);
    rst = 1'b1;

    add(1, 0, 2'd0, 7'd0, 0, P_IDLE, T_NONE);
    add_ack_packet();
    run_rows("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
